// File: rtl/imem_pipe.sv
// Instruction memory with byte-enable writes, a pipelined fetch port of configurable
// latency with out-of-range error reporting, and a one-word-per-cycle clear sequencer.
module imem_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [WIDTH-1:0]      i_data,
    output logic                  i_valid,
    output logic                  i_err,
    input  logic                  wre,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [WIDTH/8-1:0]    wr_be,
    input  logic                  clr_start,
    output logic                  busy
);

    localparam int unsigned NB       = WIDTH / 8;
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]    DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [READ_LAT-1:0] err_q, err_d;
    logic [WIDTH-1:0]    dat_q [READ_LAT];
    logic [WIDTH-1:0]    dat_d [READ_LAT];

    logic [IDX_W-1:0] wr_idx_c, rd_idx_c;
    logic             wr_ok_c, clr_we_c, rd_acc_c, rd_oob_c;
    logic [WIDTH-1:0] wr_old_c, wr_merged_c, rd_word_c;

    // Address decode and byte-lane merge for the write port
    always_comb begin
        wr_idx_c = wr_addr[IDX_W-1:0];
        rd_idx_c = i_addr[IDX_W-1:0];
        clr_we_c = (state_q == CLEAR);
        wr_ok_c  = wre && (state_q == IDLE) && ({1'b0, wr_addr} < DEPTH_X);
        rd_acc_c = i_req && (state_q == IDLE);
        rd_oob_c = ({1'b0, i_addr} >= DEPTH_X);
        wr_old_c = mem_q[wr_idx_c];
        wr_merged_c = wr_old_c;
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) begin
                wr_merged_c[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        // Write-first: a same-edge write to the fetched word is forwarded
        rd_word_c = mem_q[rd_idx_c];
        if (wr_ok_c && (wr_addr == i_addr)) begin
            rd_word_c = wr_merged_c;
        end
    end

    // Clear sequencer next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Read pipeline: stage 0 captures the fetch, later stages shift it along
    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        vld_d[0] = rd_acc_c;
        err_d[0] = rd_acc_c && rd_oob_c;
        dat_d[0] = (rd_acc_c && !rd_oob_c) ? rd_word_c : '0;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= '0;
            err_q   <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            for (int i = 0; i < READ_LAT; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_ok_c) begin
            mem_q[wr_idx_c] <= wr_merged_c;
        end
    end

    assign i_valid = vld_q[READ_LAT-1];
    assign i_err   = err_q[READ_LAT-1];
    assign i_data  = dat_q[READ_LAT-1];
    assign busy    = busy_q;

endmodule

// File: tb/tb_imem_pipe.sv
// Scoreboard bench for imem_pipe: two instances (fetch latency 1 and 3) share stimulus
// and are checked against a reference memory model.
module tb_imem_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [7:0]  i_addr = '0;
    logic        wre = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        clr_start = 1'b0;

    logic [31:0] d1, d3;
    logic        v1, v3, e1, e3, busy1, busy3;

    always #5 clk = ~clk;

    imem_pipe #(.WIDTH(32), .DEPTH(64), .ADDR_W(8), .READ_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr),
        .i_data(d1), .i_valid(v1), .i_err(e1),
        .wre(wre), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clr_start(clr_start), .busy(busy1)
    );

    imem_pipe #(.WIDTH(32), .DEPTH(64), .ADDR_W(8), .READ_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr),
        .i_data(d3), .i_valid(v3), .i_err(e3),
        .wre(wre), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .clr_start(clr_start), .busy(busy3)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] model [64];
    logic        mclr = 1'b0;
    int          mcnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d, input logic e);
        exp_t ex;
        if (v) begin
            if (q[p].size() == 0) begin
                chk($sformatf("p%0d_spurious_valid", p), 64'(v), 64'd0);
            end else begin
                ex = q[p].pop_front();
                chk($sformatf("p%0d_data", p), 64'(d), 64'(ex.data));
                chk($sformatf("p%0d_err", p), 64'(e), 64'(ex.err));
                chk($sformatf("p%0d_latency_cycle", p), 64'(cyc), 64'(ex.due));
            end
        end else begin
            chk($sformatf("p%0d_idle_data_err", p), {31'd0, e, d}, 64'd0);
            if (q[p].size() > 0 && q[p][0].due <= cyc) begin
                chk($sformatf("p%0d_missing_valid", p), 64'(v), 64'd1);
                void'(q[p].pop_front());
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        mon(0, v1, d1, e1);
        mon(1, v3, d3, e3);
    end

    // One clock of stimulus; the reference model is advanced for the same edge
    task automatic step(input logic req, input logic [7:0] addr, input logic we,
                        input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be,
                        input logic clr);
        exp_t ex;
        @(negedge clk);
        i_req = req; i_addr = addr; wre = we; wr_addr = wa; wr_data = wd; wr_be = be;
        clr_start = clr;
        if (mclr) begin
            model[mcnt] = '0;
            mcnt++;
            if (mcnt == 64) begin
                mclr = 1'b0;
                mcnt = 0;
            end
        end else begin
            if (we && wa < 8'd64) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[wa[5:0]][8*b +: 8] = wd[8*b +: 8];
                end
            end
            if (req) begin
                ex.err  = (addr >= 8'd64);
                ex.data = ex.err ? 32'd0 : model[addr[5:0]];
                ex.due  = cyc + 1;
                q[0].push_back(ex);
                ex.due  = cyc + 3;
                q[1].push_back(ex);
            end
            if (clr) begin
                mclr = 1'b1;
                mcnt = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("busy_lat1", 64'(busy1), 64'(mclr));
        chk("busy_lat3", 64'(busy3), 64'(mclr));
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 8'd0, 1'b1, a, d, be, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, a, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic fill(input logic [7:0] salt);
        for (int i = 0; i < 64; i++) wr(8'(i), {8'hA5, salt, 8'(i), 8'(i * 3 + 1)}, 4'hF);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b0; wre = 1'b0; clr_start = 1'b0;
        #1;
        chk("rst_busy_lat1", 64'(busy1), 64'd0);
        chk("rst_busy_lat3", 64'(busy3), 64'd0);
        chk("rst_valid_lat1", 64'(v1), 64'd0);
        chk("rst_valid_lat3", 64'(v3), 64'd0);
        mclr = 1'b0;
        mcnt = 0;
        q[0].delete();
        q[1].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_lat1", {30'd0, busy1, v1, e1, d1}, 64'd0);
        chk("reset_outputs_lat3", {30'd0, busy3, v3, e3, d3}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fill and back-to-back fetch
        for (int i = 1; i <= 49; i++) wr(8'(i - 1), 32'(i), 4'hF);
        for (int i = 0; i < 49; i++) rd(8'(i));
        idle(4);

        // Back-to-back then gapped fetches
        wr(8'd0, 32'hA, 4'hF); wr(8'd1, 32'hB, 4'hF);
        wr(8'd2, 32'hC, 4'hF); wr(8'd3, 32'hD, 4'hF);
        rd(8'd0); rd(8'd1); rd(8'd2); rd(8'd3);
        idle(1);
        rd(8'd0); idle(1); rd(8'd2); idle(2); rd(8'd3);
        idle(4);

        // Byte enables and same-edge write-first
        wr(8'd5, 32'h11223344, 4'hF);
        wr(8'd5, 32'hAABBCCDD, 4'b0101);
        rd(8'd5);
        wr(8'd6, 32'h0, 4'hF);
        wr(8'd7, 32'hCAFEF00D, 4'h0);
        step(1'b1, 8'd6, 1'b1, 8'd6, 32'h12345678, 4'hF, 1'b0);
        rd(8'd7);
        idle(4);

        // Out-of-range fetch and write
        fill(8'h01);
        wr(8'd70, 32'hFFFFFFFF, 4'hF);
        wr(8'd200, 32'hFFFFFFFF, 4'hF);
        rd(8'd64); rd(8'd200); rd(8'd255);
        for (int i = 0; i < 64; i++) rd(8'(i));
        idle(4);

        // Full clear with a same-edge write and ignored fetches while busy
        step(1'b1, 8'd9, 1'b1, 8'd7, 32'h77777777, 4'hF, 1'b1);
        for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b1, 8'(i), 32'hDEADBEEF, 4'hF, 1'b1);
        for (int i = 0; i < 64; i++) rd(8'(i));
        idle(4);

        // Reset mid-fetch drops in-flight responses
        fill(8'h02);
        rd(8'd1); rd(8'd2);
        do_reset();
        idle(5);

        // Reset mid-clear aborts the sweep
        step(1'b0, 8'd0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b1);
        idle(10);
        do_reset();
        for (int i = 0; i < 64; i++) rd(8'(i));
        idle(4);

        // Clear works normally after the aborted one
        step(1'b0, 8'd0, 1'b0, 8'd0, 32'd0, 4'd0, 1'b1);
        idle(64);
        for (int i = 0; i < 64; i += 7) rd(8'(i));
        rd(8'd63);
        idle(5);

        chk("scoreboard_drained_lat1", 64'(q[0].size()), 64'd0);
        chk("scoreboard_drained_lat3", 64'(q[1].size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
